// File: rtl/gcdlcm_seq_if.sv
// Core-side handshake for the gcd/lcm coprocessor: launch strobe, operands,
// stall/busy/done status and the registered result.
interface gcdlcm_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic             op_lcm;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             err;

   modport master (output start, op_lcm, srca, srcb,
                   input  stall, busy, done, result, err);
   modport slave  (input  start, op_lcm, srca, srcb,
                   output stall, busy, done, result, err);
endinterface

// File: rtl/gcdlcm_seq.sv
// Iterative gcd (subtractive Euclid) / lcm (dual accumulator) sequencer sharing one adder.
// Optional CALC iteration limit enabled by defining GCDLCM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | wait for start; latch operands; zero operands take a one-cycle detour to FIN
// CALC  | one gcd/lcm update per cycle until x==y, overflow or timeout
// FIN   | done pulse for one cycle, then back to IDLE
module gcdlcm_seq #(
   parameter int WIDTH    = 32,
   parameter int MAX_ITER = 1024
) (
   input  logic        clk,
   input  logic        reset,
   gcdlcm_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             op_q, op_d;
   logic             err_q, err_d;
   logic             zero_q, zero_d;

   logic             x_lt_y;
   logic             upd_x;
   logic [WIDTH-1:0] opnd_l, opnd_r;
   logic [WIDTH:0]   sum;
   logic             timeout;

`ifdef GCDLCM_TIMEOUT_EN
   localparam int CW = $clog2(MAX_ITER + 1);
   logic [CW-1:0] iter_q, iter_d;
   assign timeout = (iter_q == CW'(MAX_ITER - 1));
`else
   logic unused_max_iter;
   assign unused_max_iter = ^MAX_ITER;
   assign timeout         = 1'b0;
`endif

   // Shared adder/subtractor: lcm grows the smaller accumulator, gcd subtracts smaller from larger.
   always_comb begin
      x_lt_y = (x_q < y_q);
      upd_x  = op_q ? x_lt_y : ~x_lt_y;
      if (op_q) begin
         opnd_l = x_lt_y ? x_q  : y_q;
         opnd_r = x_lt_y ? a0_q : b0_q;
         sum    = {1'b0, opnd_l} + {1'b0, opnd_r};
      end else begin
         opnd_l = x_lt_y ? y_q : x_q;
         opnd_r = x_lt_y ? x_q : y_q;
         sum    = {1'b0, opnd_l} - {1'b0, opnd_r};
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      a0_d     = a0_q;
      b0_d     = b0_q;
      result_d = result_q;
      op_d     = op_q;
      err_d    = err_q;
      zero_d   = zero_q;
`ifdef GCDLCM_TIMEOUT_EN
      iter_d   = iter_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (zero_q) begin
               zero_d  = 1'b0;
               state_d = FIN;
            end else if (bus.start) begin
               x_d   = bus.srca;
               y_d   = bus.srcb;
               a0_d  = bus.srca;
               b0_d  = bus.srcb;
               op_d  = bus.op_lcm;
               err_d = 1'b0;
`ifdef GCDLCM_TIMEOUT_EN
               iter_d = '0;
`endif
               if (!bus.op_lcm && bus.srca == '0) begin
                  result_d = bus.srcb;
                  zero_d   = 1'b1;
               end else if (!bus.op_lcm && bus.srcb == '0) begin
                  result_d = bus.srca;
                  zero_d   = 1'b1;
               end else if (bus.op_lcm && (bus.srca == '0 || bus.srcb == '0)) begin
                  result_d = '0;
                  zero_d   = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (x_q == y_q) begin
               result_d = x_q;
               state_d  = FIN;
            end else if (timeout || (op_q && sum[WIDTH])) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = FIN;
            end else begin
               if (upd_x) x_d = sum[WIDTH-1:0];
               else       y_d = sum[WIDTH-1:0];
`ifdef GCDLCM_TIMEOUT_EN
               iter_d = iter_q + 1'b1;
`endif
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         a0_q     <= '0;
         b0_q     <= '0;
         result_q <= '0;
         op_q     <= 1'b0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
`ifdef GCDLCM_TIMEOUT_EN
         iter_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         a0_q     <= a0_d;
         b0_q     <= b0_d;
         result_q <= result_d;
         op_q     <= op_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
`ifdef GCDLCM_TIMEOUT_EN
         iter_q   <= iter_d;
`endif
      end
   end

   assign bus.busy   = (state_q == CALC);
   assign bus.done   = (state_q == FIN);
   assign bus.stall  = bus.start & ~bus.done;
   assign bus.result = result_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_gcdlcm_seq.sv
// Randomized self-checking bench for gcdlcm_seq against a closed-form gcd/lcm model.
module tb_gcdlcm_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   gcdlcm_seq_if #(.WIDTH(W)) bus ();
   gcdlcm_seq #(.WIDTH(W), .MAX_ITER(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_gcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Returns {err, result} for the requested operation.
   function automatic logic [32:0] m_result(input bit op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned l;
      if (!op) return {1'b0, m_gcd(a, b)};
      if (a == 0 || b == 0) return 33'd0;
      l = (longint'(a) / longint'(m_gcd(a, b))) * longint'(b);
      if (l > 64'hFFFF_FFFF) return {1'b1, 32'd0};
      return {1'b0, l[31:0]};
   endfunction

   // Clock edges from the start-sampling edge to the edge that enters FIN.
   function automatic int m_edges(input bit op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned x = a, y = b;
      int n = 0;
      if (a == 0 || b == 0) return 2;
      while (x != y && n < 100000) begin
         if (op) begin
            if (x < y) x += a; else y += b;
            if (x > 64'hFFFF_FFFF || y > 64'hFFFF_FFFF) break;
         end else begin
            if (x > y) x -= y; else y -= x;
         end
         n++;
      end
      return n + 2;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk("stall_comb", bus.stall, bus.start & ~bus.done);
         chk("busy_done_excl", bus.busy & bus.done, 1'b0);
         if (bus.done) done_cnt++;
      end
   end

   task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b, input bit keep_start);
      logic [32:0] exp;
      int          exp_e, e;
      bit          saw_busy;
      exp   = m_result(op, a, b);
      exp_e = m_edges(op, a, b);
      if (bus.done) begin
         @(posedge clk); #1;
         chk("done_one_cycle", bus.done, 1'b0);
      end
      bus.start = 1'b1; bus.op_lcm = op; bus.srca = a; bus.srcb = b;
      e = 0; saw_busy = 0;
      do begin
         @(posedge clk); #1;
         e++;
         if (bus.busy) saw_busy = 1;
         bus.srca = $urandom; bus.srcb = $urandom; bus.op_lcm = 1'($urandom);
      end while (!bus.done && e < 3000);
      chk("latency", 64'(e), 64'(exp_e));
      chk("result", bus.result, exp[31:0]);
      chk("err", bus.err, exp[32]);
      chk("stall_at_done", bus.stall, 1'b0);
      if (a == 0 || b == 0) chk("zero_no_busy", saw_busy, 1'b0);
      if (!keep_start) begin
         bus.start = 1'b0;
         @(posedge clk); #1;
         chk("done_pulse_end", bus.done, 1'b0);
         chk("result_held", bus.result, exp[31:0]);
         chk("err_held", bus.err, exp[32]);
      end
   endtask

   initial begin
      int d0;
      reset = 1'b1;
      bus.start = 1'b0; bus.op_lcm = 1'b0; bus.srca = '0; bus.srcb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_err", bus.err, 1'b0);
      reset = 1'b0;

      chk("pin_gcd", m_gcd(32'd12, 32'd8), 32'd4);
      chk("pin_gcd_edges", 64'(m_edges(0, 32'd12, 32'd8)), 64'd4);
      chk("pin_lcm", m_result(1, 32'd4, 32'd6), 33'd12);
      chk("pin_lcm_edges", 64'(m_edges(1, 32'd4, 32'd6)), 64'd5);
      chk("pin_ovf", m_result(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE), {1'b1, 32'd0});

      run_op(0, 32'd12, 32'd8, 0);
      chk("lit_gcd12_8", bus.result, 32'd4);
      run_op(1, 32'd4, 32'd6, 0);
      chk("lit_lcm4_6", bus.result, 32'd12);
      run_op(0, 32'd0, 32'd7, 0);
      chk("lit_gcd0_7", bus.result, 32'd7);
      run_op(1, 32'd0, 32'd9, 0);
      chk("lit_lcm0_9", bus.result, 32'd0);
      run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      chk("lit_ovf_err", bus.err, 1'b1);
      run_op(0, 32'd9, 32'd6, 0);
      chk("lit_gcd9_6", bus.result, 32'd3);
      chk("lit_gcd9_6_err", bus.err, 1'b0);

      // Reset lands on edge 10 of a long gcd(1000,1).
      bus.start = 1'b1; bus.op_lcm = 1'b0; bus.srca = 32'd1000; bus.srcb = 32'd1;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1; bus.start = 1'b0;
      @(posedge clk); #1;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_err", bus.err, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_no_done", bus.done, 1'b0);
      run_op(0, 32'd6, 32'd4, 0);
      chk("lit_gcd6_4", bus.result, 32'd2);

      d0 = done_cnt;
      run_op(0, 32'd12, 32'd8, 1);
      run_op(0, 32'd15, 32'd10, 0);
      chk("b2b_result", bus.result, 32'd5);
      chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

      for (int i = 0; i < 40; i++) begin
         bit          op;
         logic [31:0] a, b;
         int          sel;
         op  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         a   = $urandom_range(1, 200);
         b   = $urandom_range(1, 200);
         if (sel == 0) a = 0;
         if (sel == 1) b = 0;
         if (sel == 2 && op) begin
            a = $urandom | 32'h8000_0000;
            b = $urandom | 32'h4000_0000;
         end
         run_op(op, a, b, bit'($urandom_range(0, 1)));
      end
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
